mole_tile_writer: RTL and testbench
===================================

Name: mole_tile_writer

Overview:
- Framebuffer write-side engine for the whack-a-mole display.
- Takes a hole index and mole state (up or down) and sweeps one sprite tile out of the sprite ROM.
- Issues pixel plot writes (x, y, colour, plot) to the VGA adapter, placing the tile at the hole's position on a 4x4 grid of the 160x120 screen.
- Sits between the mole control path (hole select, mole_up) and the vga_adapter.

Parameters:
- TILE_W, 40, tile width in pixels.
- TILE_H, 30, tile height in pixels.
- COLOUR_W, 3, colour bits per pixel.
- ADDR_W, 12, sprite ROM address width; must hold 2*TILE_W*TILE_H.
- TRANSP_KEY, 3'b101, colour code treated as transparent (used only with TRANSPARENT_EN).

Ports:
- clock  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to draw one tile; sampled only in IDLE.
- hole  input  4  tile position; hole[1:0] = column, hole[3:2] = row.
- mole_up  input  1  1 = mole sprite (ROM sprite 1), 0 = empty-hole sprite (ROM sprite 0).
- rom_addr  output  ADDR_W  sprite ROM read address.
- rom_data  input  COLOUR_W  ROM read data, valid exactly 1 cycle after rom_addr.
- x  output  8  plot x coordinate.
- y  output  7  plot y coordinate.
- colour  output  COLOUR_W  plot colour.
- plot  output  1  write strobe to vga_adapter.
- busy  output  1  high whenever not in IDLE.
- done  output  1  one-cycle pulse at tile completion.

Behaviour:
- Reset:
  - State goes to IDLE.
  - rom_addr, x, y, colour, plot, busy and done all go to 0.
  - Reset overrides every other input in any state, including mid-draw; the partial tile is abandoned and no done pulse is issued.
- Constants:
  - N = TILE_W*TILE_H pixels per tile.
  - Tile origin: x0 = hole[1:0]*TILE_W, y0 = hole[3:2]*TILE_H.
  - Sprite base: 0 if mole_up=0, N if mole_up=1.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE:
  - busy=0, plot=0.
  - If start=1, latch hole, mole_up, origin and base, clear col/row counters, and go to DRAW.
- DRAW:
  - Each cycle, rom_addr = base + row*TILE_W + col.
  - The address is generated by an incrementing counter; no multiplier is allowed in the address path.
  - col increments; at TILE_W-1 it wraps to 0 and row increments.
  - The issued pixel's coordinates are piped one stage to align with rom_data.
  - After the address for (col=TILE_W-1, row=TILE_H-1) is issued, go to FLUSH.
- Plot stage:
  - In the cycle after each DRAW address, plot=1 with x=x0+col_d, y=y0+row_d and colour=rom_data.
  - The FLUSH cycle carries the final pixel's plot.
- DONE: done=1 for one cycle, plot=0, then unconditionally return to IDLE.
- Timing (start sampled at edge t):
  - DRAW occupies t+1..t+N.
  - plot is high on t+2..t+N+1.
  - DONE is at t+N+2.
  - IDLE is at t+N+3.
  - Exactly N plot strobes per tile, in raster order (row-major, col fastest).
- busy is 1 in DRAW, FLUSH and DONE.
- start while busy=1 (including in DONE) is ignored; it is not queued.
- hole and mole_up changes after the start cycle have no effect on the tile in progress.
- Coordinate ranges:
  - x maxes at 3*TILE_W+TILE_W-1 = 159; y maxes at 119.
  - No wrap-around occurs; widths are sized so no truncation happens with the default parameters.
- x, y and colour hold their last values when plot=0.

Optional Feature:
- Macro: TRANSPARENT_EN.
- Defined: in the plot stage, a pixel whose rom_data == TRANSP_KEY gets plot=0 that cycle.
  - Counters, addresses, timing and the done cycle are unchanged.
  - The plot count is N minus the number of keyed pixels.
- Undefined: every pixel is plotted; TRANSP_KEY is unused.

Test Plan:
- Reset hold 3 cycles then release -> all outputs 0, busy=0; asserting reset mid-operation gives the same result.
- start=1, hole=4'd5, mole_up=1 at edge t:
  - First plot at t+2 with x=40, y=30, colour=ROM[1200].
  - Last plot at t+1201 with x=79, y=59, colour=ROM[2399].
  - done=1 at t+1202 only; total of 1200 plots.
- start=1, hole=4'd15, mole_up=0 -> rom_addr sweeps 0..1199; x spans 120..159, y spans 90..119; no plot outside this box.
- start pulsed again at t+10 and at DONE, with hole changed to 0 at t+5 -> ignored; the single tile still completes at hole 5; next start from IDLE is accepted.
- reset asserted at the 100th DRAW cycle -> next cycle plot=0, busy=0, no done; a subsequent start redraws from pixel (0,0).
- With TRANSPARENT_EN and a ROM model returning 3'b101 at even addresses -> exactly 600 plots, all at odd addresses, with done timing identical to the non-transparent case.

Source files
------------

// File: rtl/mole_tile_writer.sv
// mole_tile_writer
//   Framebuffer write-side engine for the whack-a-mole display. On a start
//   request it sweeps one TILE_W x TILE_H sprite out of the sprite ROM and
//   issues raster-ordered plot writes to the VGA adapter, placing the tile at
//   one cell of a 4x4 grid on the 160x120 screen.
//
//   Optional build macro: TRANSPARENT_EN
//     defined   - pixels whose ROM colour equals TRANSP_KEY are not plotted
//     undefined - every pixel is plotted
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   start     in   draw request, sampled only while idle
//   hole      in   [1:0] = column, [3:2] = row of the tile
//   mole_up   in   1 = mole sprite (ROM sprite 1), 0 = empty-hole sprite
//   rom_addr  out  sprite ROM read address
//   rom_data  in   ROM data, valid one cycle after rom_addr
//   x, y      out  plot coordinates
//   colour    out  plot colour
//   plot      out  write strobe
//   busy      out  high whenever not idle
//   done      out  one-cycle pulse at tile completion
//
// State table
//   S_IDLE  | waiting for start
//   S_DRAW  | one ROM address per cycle, raster order
//   S_FLUSH | final pixel's plot while no new address is issued
//   S_DONE  | done pulse, back to idle next cycle

module mole_tile_writer #(
    parameter int                   TILE_W     = 40,
    parameter int                   TILE_H     = 30,
    parameter int                   COLOUR_W   = 3,
    parameter int                   ADDR_W     = 12,
    parameter logic [COLOUR_W-1:0]  TRANSP_KEY = 3'b101
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          hole,
    input  logic                mole_up,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int N  = TILE_W * TILE_H;
    localparam int CW = $clog2(TILE_W);
    localparam int RW = $clog2(TILE_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_x0;
    logic [6:0]          r_y0;
    logic [7:0]          r_x_d;
    logic [6:0]          r_y_d;
    logic                r_pix_v;
    logic [7:0]          r_x_hold;
    logic [6:0]          r_y_hold;
    logic [COLOUR_W-1:0] r_c_hold;

    logic                w_last;
    logic                w_col_wrap;
    logic                w_keyed;
    logic                w_plot;
    logic [7:0]          w_x0;
    logic [6:0]          w_y0;
    logic [ADDR_W-1:0]   w_base;

    assign w_col_wrap = (r_col == CW'(TILE_W - 1));
    assign w_last     = w_col_wrap && (r_row == RW'(TILE_H - 1));

    // Origin uses small constant products on the 2-bit grid index only;
    // the ROM address itself is a plain incrementing counter.
    assign w_x0   = 8'(TILE_W) * {6'b0, hole[1:0]};
    assign w_y0   = 7'(TILE_H) * {5'b0, hole[3:2]};
    assign w_base = mole_up ? ADDR_W'(N) : '0;

`ifdef TRANSPARENT_EN
    assign w_keyed = (rom_data == TRANSP_KEY);
`else
    // Key compare masked off: every pixel is plotted in this build.
    assign w_keyed = 1'b0 & (rom_data == TRANSP_KEY);
`endif

    assign w_plot = r_pix_v && !w_keyed;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAW;
            S_DRAW:  if (w_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_col    <= '0;
            r_row    <= '0;
            r_addr   <= '0;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x_d    <= '0;
            r_y_d    <= '0;
            r_pix_v  <= 1'b0;
            r_x_hold <= '0;
            r_y_hold <= '0;
            r_c_hold <= '0;
        end else begin
            r_state <= w_next;
            // A pixel enters the plot stage one cycle after its address.
            r_pix_v <= (r_state == S_DRAW);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0   <= w_x0;
                        r_y0   <= w_y0;
                        r_addr <= w_base;
                        r_col  <= '0;
                        r_row  <= '0;
                    end
                end
                S_DRAW: begin
                    r_x_d <= r_x0 + 8'(r_col);
                    r_y_d <= r_y0 + 7'(r_row);
                    // Address stays on the last pixel once the sweep ends.
                    if (!w_last) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (w_plot) begin
                r_x_hold <= r_x_d;
                r_y_hold <= r_y_d;
                r_c_hold <= rom_data;
            end
        end
    end

    // Colour comes straight from the ROM during a plot; outside a plot the
    // last plotted values are held.
    assign rom_addr = r_addr;
    assign plot     = w_plot;
    assign x        = w_plot ? r_x_d    : r_x_hold;
    assign y        = w_plot ? r_y_d    : r_y_hold;
    assign colour   = w_plot ? rom_data : r_c_hold;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_mole_tile_writer.sv
module tb_mole_tile_writer;

    localparam int TW = 40;
    localparam int TH = 30;
    localparam int N  = TW * TH;

    logic        clock;
    logic        reset;
    logic        start;
    logic [3:0]  hole;
    logic        mole_up;
    logic [11:0] rom_addr;
    logic [2:0]  rom_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [2:0] mem [0:2*N-1];
    int last_x, last_y, last_c;

    mole_tile_writer dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .hole     (hole),
        .mole_up  (mole_up),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous sprite ROM: data one cycle after address.
    always @(posedge clock)
        rom_data <= (int'(rom_addr) < 2*N) ? mem[rom_addr] : 3'd0;

    function automatic bit keyed(input int a);
`ifdef TRANSPARENT_EN
        return mem[a] == 3'b101;
`else
        return (a < 0);
`endif
    endfunction

    task automatic check_idle_zero(input string tag);
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 12'd0 ||
            x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
            errors++;
            $display("FAIL %s: plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d c=%0d, required all 0",
                     tag, plot, busy, done, rom_addr, x, y, colour);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_idle_zero("reset_hold");
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check_idle_zero("reset_release");
        last_x = 0; last_y = 0; last_c = 0;
    endtask

    // Draws one tile and checks every cycle against the raster model.
    // Call with inputs idle, 1 time unit after a rising edge.
    task automatic test_tile(input logic [3:0] h, input logic m, input bit disturb);
        int base, p, nplot, exp_nplot, ex, ey, ec;
        bit exp_plot, exp_busy, exp_done;
        base = m ? N : 0;
        nplot = 0; exp_nplot = 0;
        hole = h; mole_up = m; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int e = 0; e <= N + 2; e++) begin
            p        = e - 1;
            exp_busy = (e <= N + 1);
            exp_done = (e == N + 1);
            exp_plot = (e >= 1 && e <= N) && !keyed(base + p);

            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy h=%0d e=%0d: got %b want %b", h, e, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done h=%0d e=%0d: got %b want %b", h, e, done, exp_done);
            end
            checks++;
            if (plot !== exp_plot) begin
                errors++;
                $display("FAIL plot h=%0d e=%0d: got %b want %b", h, e, plot, exp_plot);
            end
            if (e < N) begin
                checks++;
                if (int'(rom_addr) != base + e) begin
                    errors++;
                    $display("FAIL rom_addr h=%0d e=%0d: got %0d want %0d", h, e, rom_addr, base + e);
                end
            end
            if (exp_plot) begin
                ex = int'(h[1:0]) * TW + p % TW;
                ey = int'(h[3:2]) * TH + p / TW;
                ec = int'(mem[base + p]);
                checks++;
                if (int'(x) != ex || int'(y) != ey || int'(colour) != ec) begin
                    errors++;
                    $display("FAIL pixel h=%0d p=%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                             h, p, x, y, colour, ex, ey, ec);
                end
                last_x = ex; last_y = ey; last_c = ec;
                exp_nplot++;
            end
            if (plot === 1'b1) nplot++;
            if (e == N + 2) begin
                checks++;
                if (int'(x) != last_x || int'(y) != last_y || int'(colour) != last_c) begin
                    errors++;
                    $display("FAIL hold h=%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d",
                             h, x, y, colour, last_x, last_y, last_c);
                end
            end
            if (disturb) begin
                if (e == 4) begin
                    hole = 4'd0;
                    mole_up = ~m;
                end
                start = (e == 9 || e == N + 1);
            end
            if (e < N + 2) begin
                @(posedge clock); #1;
            end
        end
        start = 1'b0;
        checks++;
        if (nplot != exp_nplot) begin
            errors++;
            $display("FAIL plot_count h=%0d: got %0d want %0d", h, nplot, exp_nplot);
        end
    endtask

    task automatic test_reset_mid(input logic [3:0] h, input logic m);
        hole = h; mole_up = m; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int e = 1; e < 100; e++) begin
            @(posedge clock); #1;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            check_idle_zero("reset_mid");
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check_idle_zero("reset_mid_release");
        last_x = 0; last_y = 0; last_c = 0;
        test_tile(h, m, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hole = 4'd0; mole_up = 1'b0;
        for (int a = 0; a < 2 * N; a++) begin
`ifdef TRANSPARENT_EN
            if (a % 2 == 0) mem[a] = 3'b101;
            else begin
                int v;
                v = int'($urandom_range(0, 6));
                if (v >= 5) v++;
                mem[a] = 3'(v);
            end
`else
            mem[a] = 3'($urandom_range(0, 7));
`endif
        end

        test_reset();
        test_tile(4'd5, 1'b1, 1'b0);
        test_tile(4'd15, 1'b0, 1'b0);
        test_tile(4'd5, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            test_tile(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        test_reset_mid(4'd10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
